// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
// Module   : alu_cmd_sequencer_if
// Brief    : Command, ALU-side and response signals of alu_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic [TAG_W-1:0] rsp_tag;

    // Sequencer side: drives the ALU and the response channel.
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_op, alu_en,
        input  alu_result, alu_zero, alu_overflow,
        output rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag,
        input  rsp_ready
    );

    // Environment side: command producer, ALU and response consumer.
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op, alu_en,
        output alu_result, alu_zero, alu_overflow,
        input  rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag,
        output rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Buffers tagged ALU commands, issues them one at a time to a
//            registered ALU and returns tagged responses in command order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    alu_cmd_sequencer_if.master bus,
    output logic                busy,
    output logic [15:0]         done_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q, state_d;
    cmd_t             iss_q, iss_d;
    logic             alu_en_q, alu_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [15:0]      done_count_q, done_count_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic rsp_hs;
    cmd_t cmd_in;

    assign cmd_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};

    always_comb begin
        fifo_empty = (count_q == '0);
        push       = bus.cmd_valid && (count_q != FULL_COUNT);
        rsp_hs     = rsp_valid_q && bus.rsp_ready;
        // A pop always hands the head straight to the ISSUE cycle.
        pop        = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_hs));

        wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d        = count_q;
        state_d        = state_q;
        iss_d          = pop ? mem_q[rd_ptr_q] : iss_q;
        alu_en_d       = pop;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_tag_d      = rsp_tag_q;
        done_count_d   = rsp_hs ? done_count_q + 16'd1 : done_count_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (pop) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Logical ops leave the ALU overflow register untouched.
                rsp_result_d   = bus.alu_result;
                rsp_zero_d     = bus.alu_zero;
                rsp_overflow_d = bus.alu_overflow &&
                                 ((iss_q.op == OP_ADD) || (iss_q.op == OP_SUB));
                rsp_tag_d      = iss_q.tag;
                rsp_valid_d    = 1'b1;
                state_d        = ST_RESP;
            end
            default: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = pop ? ST_ISSUE : ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= ST_IDLE;
            iss_q          <= '0;
            alu_en_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_tag_q      <= '0;
            done_count_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            iss_q          <= iss_d;
            alu_en_q       <= alu_en_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_tag_q      <= rsp_tag_d;
            done_count_q   <= done_count_d;
        end
    end

    assign bus.cmd_ready    = (count_q != FULL_COUNT);
    assign bus.alu_a        = iss_q.a;
    assign bus.alu_b        = iss_q.b;
    assign bus.alu_op       = iss_q.op;
    assign bus.alu_en       = alu_en_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_tag      = rsp_tag_q;
    assign busy             = (state_q != ST_IDLE) || !fifo_empty;
    assign done_count       = done_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Self-checking bench for alu_cmd_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] done_count;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_cmd_sequencer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.master),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       v;
        logic [3:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int    en_pulses = 0;
    int    rsp_seen  = 0;
    logic  prev_en   = 1'b0;
    logic  stall_q   = 1'b0;
    logic [13:0] held = '0;
    bit    rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return 8'(a + b);
            3'd1:    return 8'(a - b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (a == b) ? 8'd1 : 8'd0;
            3'd6:    return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = ref_res(op, a, b);
        if (op == 3'd0) return (a[7] == b[7]) && (s[7] != a[7]);
        if (op == 3'd1) return (a[7] != b[7]) && (s[7] != a[7]);
        return 1'b0;
    endfunction

    // Behavioural ALU: registered outputs, overflow held through logical ops.
    logic [7:0] m_res = '0;
    logic       m_z   = 1'b0;
    logic       m_v   = 1'b0;
    always @(posedge clk) begin
        if (bus.alu_en) begin
            m_res <= ref_res(bus.alu_op, bus.alu_a, bus.alu_b);
            m_z   <= (ref_res(bus.alu_op, bus.alu_a, bus.alu_b) == 8'd0);
            if (bus.alu_op == 3'd0 || bus.alu_op == 3'd1)
                m_v <= ref_ovf(bus.alu_op, bus.alu_a, bus.alu_b);
        end
    end
    assign bus.alu_result   = m_res;
    assign bus.alu_zero     = m_z;
    assign bus.alu_overflow = m_v;

    // Response monitor and scoreboard checker.
    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (bus.alu_en) begin
                en_pulses++;
                chk("alu_en_one_cycle", {31'd0, prev_en}, 32'd0);
            end
            prev_en = bus.alu_en;
            if (stall_q && bus.rsp_valid)
                chk("rsp_stable", {18'd0, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_tag},
                    {18'd0, held});
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_result",   {24'd0, bus.rsp_result}, {24'd0, mon_e.res});
                    chk("rsp_zero",     {31'd0, bus.rsp_zero},     {31'd0, mon_e.z});
                    chk("rsp_overflow", {31'd0, bus.rsp_overflow}, {31'd0, mon_e.v});
                    chk("rsp_tag",      {28'd0, bus.rsp_tag},      {28'd0, mon_e.tag});
                end
            end
            stall_q = bus.rsp_valid && !bus.rsp_ready;
            held    = {bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_tag};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        exp_t e;
        int   n;
        logic acc;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        if (acc) begin
            e.res = ref_res(op, a, b);
            e.z   = (e.res == 8'd0);
            e.v   = ref_ovf(op, a, b);
            e.tag = tag;
            sb.push_back(e);
        end else begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || bus.rsp_valid || sb.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n < 1000)}, 32'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_alu_bus", {13'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_en}, 32'd0);
        chk("rst_rsp", {17'd0, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow, bus.rsp_tag}, 32'd0);
        chk("rst_busy_done", {15'd0, busy, done_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int cyc;
        int seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Single ADD: latency E0 -> E3 and a single enable pulse.
        p = en_pulses;
        send(3'd0, 8'd5, 8'd3, 4'd1);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, 32'd3);
        tick();
        chk("rsp_valid_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
        wait_idle("t1_idle");
        chk("t1_en_pulses", en_pulses - p, 32'd1);
        p = en_pulses;
        repeat (5) tick();
        chk("idle_no_en", en_pulses - p, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Overflow then masked logical op; SUB overflow then CMP.
        send(3'd0, 8'h7F, 8'h01, 4'd2);
        send(3'd2, 8'h0F, 8'hF0, 4'd3);
        wait_idle("t2_idle");
        send(3'd1, 8'h80, 8'h01, 4'd4);
        send(3'd5, 8'h03, 8'h03, 4'd5);
        wait_idle("t3_idle");

        // Backpressure: fill the FIFO behind a stalled response.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'd0, 8'(i), 8'(i), 4'(i));
        chk("full_after_5", {31'd0, bus.cmd_ready}, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'd5;
        bus.cmd_b     = 8'd5;
        bus.cmd_tag   = 4'd5;
        repeat (3) begin
            tick();
            chk("sixth_stalled", {31'd0, bus.cmd_ready}, 32'd0);
        end
        chk("stalled_done_count", {16'd0, done_count}, 32'd0);
        bus.rsp_ready = 1'b1;
        send(3'd0, 8'd5, 8'd5, 4'd5);
        wait_idle("t4_idle");
        chk("done_count_6", {16'd0, done_count}, 32'd6);
        chk("busy_after_drain", {31'd0, busy}, 32'd0);

        // Asynchronous reset in CAPTURE with two commands queued.
        send(3'd0, 8'd1, 8'd1, 4'd6);
        send(3'd0, 8'd2, 8'd2, 4'd7);
        send(3'd0, 8'd3, 8'd3, 4'd8);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        seen = rsp_seen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) tick();
        chk("no_stale_rsp", rsp_seen - seen, 32'd0);
        chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);

        // Random ops with random response stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++)
            send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 4'(i));
        rand_ready    = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle("rand_idle");
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
